// File: rtl/usr_pkg.sv
// Shared mode encodings and FSM state type for the N-bit universal shift register.
package usr_pkg;

    localparam logic [1:0] MODE_HOLD = 2'b00;
    localparam logic [1:0] MODE_SHR  = 2'b01;
    localparam logic [1:0] MODE_SHL  = 2'b10;
    localparam logic [1:0] MODE_LOAD = 2'b11;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } usr_state_t;

endpackage

// File: rtl/usr_step.sv
// One-step next-value function of the shift register.
// Shared by the single-step path and the multi-step engine.
module usr_step
    import usr_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] cur,
    input  logic [1:0]       mode,
    input  logic             right_in,
    input  logic             left_in,
    input  logic             rotate,
    input  logic [WIDTH-1:0] load_data,
    output logic [WIDTH-1:0] nxt
);

    always_comb begin
        nxt = cur;
        case (mode)
            MODE_SHR:  nxt = {(rotate ? cur[0] : right_in), cur[WIDTH-1:1]};
            MODE_SHL:  nxt = {cur[WIDTH-2:0], (rotate ? cur[WIDTH-1] : left_in)};
            MODE_LOAD: nxt = load_data;
            default:   nxt = cur;
        endcase
    end

endmodule

// File: rtl/universal_shift_register_n.sv
// N-bit universal shift register with a multi-step shift engine (busy/done handshake).
// Optional rotate input enabled by defining USR_ROTATE_EN.
//
// state | meaning
// IDLE  | single-step mode operation each edge; accepts start requests
// SHIFT | multi-step shift in progress in the latched direction; busy=1
module universal_shift_register_n
    import usr_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             S1,
    input  logic             S0,
    input  logic             right_in,
    input  logic             left_in,
    input  logic [WIDTH-1:0] inputs,
    input  logic             start,
    input  logic [CNT_W-1:0] amount,
`ifdef USR_ROTATE_EN
    input  logic             rotate,
`endif
    output logic [WIDTH-1:0] out,
    output logic             right_shift,
    output logic             left_shift,
    output logic             busy,
    output logic             done
);

    usr_state_t       state, state_d;
    logic [CNT_W-1:0] count, count_d;
    logic [1:0]       dir, dir_d;
    logic             rot_q, rot_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic             busy_d, done_d;

    logic [1:0]       mode;
    logic             rot_live;
    logic [1:0]       step_mode;
    logic             step_rot;
    logic [WIDTH-1:0] step_nxt;

    assign mode = {S1, S0};

`ifdef USR_ROTATE_EN
    assign rot_live = rotate;
`else
    assign rot_live = 1'b0;
`endif

    // While busy the step uses only the latched direction/rotate; live mode is ignored.
    always_comb begin
        step_mode = mode;
        step_rot  = rot_live;
        if (state == SHIFT) begin
            step_mode = dir;
            step_rot  = rot_q;
        end
    end

    usr_step #(.WIDTH(WIDTH)) u_step (
        .cur       (out_q),
        .mode      (step_mode),
        .right_in  (right_in),
        .left_in   (left_in),
        .rotate    (step_rot),
        .load_data (inputs),
        .nxt       (step_nxt)
    );

    always_comb begin
        state_d = state;
        count_d = count;
        dir_d   = dir;
        rot_d   = rot_q;
        out_d   = step_nxt;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        case (state)
            IDLE: begin
                if (start && (mode == MODE_SHR || mode == MODE_SHL)) begin
                    dir_d = mode;
                    rot_d = rot_live;
                    if (amount == '0) begin
                        out_d  = out_q;
                        done_d = 1'b1;
                    end else begin
                        // First shift happens on the accepting edge itself.
                        count_d = amount - 1'b1;
                        if (amount != CNT_W'(1)) begin
                            state_d = SHIFT;
                            busy_d  = 1'b1;
                        end else begin
                            done_d = 1'b1;
                        end
                    end
                end
            end
            SHIFT: begin
                count_d = count - 1'b1;
                if (count == CNT_W'(1)) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    busy_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                out_d   = out_q;
            end
        endcase
    end

    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            state <= IDLE;
            count <= '0;
            dir   <= MODE_HOLD;
            rot_q <= 1'b0;
            out_q <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_d;
            count <= count_d;
            dir   <= dir_d;
            rot_q <= rot_d;
            out_q <= out_d;
            busy  <= busy_d;
            done  <= done_d;
        end
    end

    assign out         = out_q;
    assign right_shift = out_q[0];
    assign left_shift  = out_q[WIDTH-1];

endmodule

// File: tb/tb_universal_shift_register_n.sv
// Directed self-checking bench for universal_shift_register_n (WIDTH=8, CNT_W=4).
module tb_universal_shift_register_n;

    logic       clk = 1'b0;
    logic       clear;
    logic       S1, S0, right_in, left_in, start;
    logic [7:0] inputs;
    logic [3:0] amount;
    logic       rotate;
    logic [7:0] out;
    logic       right_shift, left_shift, busy, done;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    universal_shift_register_n #(.WIDTH(8), .CNT_W(4)) dut (
        .clk         (clk),
        .clear       (clear),
        .S1          (S1),
        .S0          (S0),
        .right_in    (right_in),
        .left_in     (left_in),
        .inputs      (inputs),
        .start       (start),
        .amount      (amount),
`ifdef USR_ROTATE_EN
        .rotate      (rotate),
`endif
        .out         (out),
        .right_shift (right_shift),
        .left_shift  (left_shift),
        .busy        (busy),
        .done        (done)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_mode(input logic [1:0] m);
        {S1, S0} = m;
    endtask

    task automatic load(input logic [7:0] v);
        start = 1'b0;
        set_mode(2'b11);
        inputs = v;
        tick();
        set_mode(2'b00);
    endtask

    // Ticks until done is seen; n = edges taken, or -1 on timeout.
    task automatic wait_done(input int max_cyc, output int n);
        n = -1;
        for (int i = 1; i <= max_cyc; i++) begin
            tick();
            if (done) begin
                n = i;
                break;
            end
        end
    endtask

    int n;

    initial begin
        clear = 1'b0; S1 = 0; S0 = 0; right_in = 0; left_in = 0; start = 0;
        inputs = '0; amount = '0; rotate = 1'b0;
        #2;
        check("reset_out", 32'(out), 32'h00);
        check("reset_busy", 32'(busy), 32'h0);
        check("reset_done", 32'(done), 32'h0);
        #10 clear = 1'b1;

        // single-step load then right shift
        set_mode(2'b11); inputs = 8'h3C; tick();
        check("load_3C", 32'(out), 32'h3C);
        set_mode(2'b01); right_in = 1'b1; tick();
        check("shr_9E", 32'(out), 32'h9E);
        check("right_shift_bit", 32'(right_shift), 32'h0);
        check("left_shift_bit", 32'(left_shift), 32'h1);
        right_in = 1'b0;

        // multi-step left shift by 3
        load(8'h81);
        set_mode(2'b10); left_in = 1'b0; start = 1'b1; amount = 4'd3; tick();
        start = 1'b0; set_mode(2'b00);
        check("shl3_e1_out", 32'(out), 32'h02);
        check("shl3_e1_busy", 32'(busy), 32'h1);
        tick();
        check("shl3_e2_out", 32'(out), 32'h04);
        check("shl3_e2_busy", 32'(busy), 32'h1);
        check("shl3_e2_done", 32'(done), 32'h0);
        tick();
        check("shl3_out", 32'(out), 32'h08);
        check("shl3_done", 32'(done), 32'h1);
        check("shl3_busy_low", 32'(busy), 32'h0);
        tick();
        check("shl3_done_drop", 32'(done), 32'h0);
        check("shl3_hold", 32'(out), 32'h08);

        // amount = 0
        load(8'h55);
        set_mode(2'b01); start = 1'b1; amount = 4'd0; tick();
        start = 1'b0; set_mode(2'b00);
        check("amt0_out", 32'(out), 32'h55);
        check("amt0_done", 32'(done), 32'h1);
        check("amt0_busy", 32'(busy), 32'h0);
        tick();
        check("amt0_done_drop", 32'(done), 32'h0);

        // inputs ignored while busy, then back-to-back start in the done cycle
        load(8'hF0);
        set_mode(2'b01); right_in = 1'b0; start = 1'b1; amount = 4'd3; tick();
        check("ign_e1", 32'(out), 32'h78);
        set_mode(2'b11); inputs = 8'hFF; amount = 4'd5; tick();
        check("ign_e2", 32'(out), 32'h3C);
        check("ign_e2_busy", 32'(busy), 32'h1);
        tick();
        check("ign_result", 32'(out), 32'h1E);
        check("ign_done", 32'(done), 32'h1);
        set_mode(2'b10); left_in = 1'b1; start = 1'b1; amount = 4'd1; tick();
        start = 1'b0; set_mode(2'b00); left_in = 1'b0;
        check("b2b_out", 32'(out), 32'h3D);
        check("b2b_done", 32'(done), 32'h1);
        check("b2b_busy", 32'(busy), 32'h0);
        tick();
        check("b2b_done_drop", 32'(done), 32'h0);

        // amount above WIDTH shifts everything out
        load(8'hFF);
        set_mode(2'b01); right_in = 1'b0; start = 1'b1; amount = 4'd12; tick();
        start = 1'b0; set_mode(2'b00);
        wait_done(20, n);
        check("amt12_cycles", 32'(n), 32'd11);
        check("amt12_out", 32'(out), 32'h00);

        // asynchronous clear mid-operation
        load(8'hA5);
        set_mode(2'b01); right_in = 1'b1; start = 1'b1; amount = 4'd5; tick();
        start = 1'b0; set_mode(2'b00);
        check("clr_pre_out", 32'(out), 32'hD2);
        check("clr_pre_busy", 32'(busy), 32'h1);
        #2 clear = 1'b0;
        #1;
        check("clr_out", 32'(out), 32'h00);
        check("clr_busy", 32'(busy), 32'h0);
        check("clr_done", 32'(done), 32'h0);
        #3 clear = 1'b1;
        right_in = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("clr_no_done", 32'(done), 32'h0);
        end
        check("clr_no_busy", 32'(busy), 32'h0);

`ifdef USR_ROTATE_EN
        load(8'h81);
        set_mode(2'b01); rotate = 1'b1; start = 1'b1; amount = 4'd4; tick();
        start = 1'b0; set_mode(2'b00); rotate = 1'b0;
        wait_done(10, n);
        check("rot4_cycles", 32'(n), 32'd3);
        check("rot4_out", 32'(out), 32'h18);
        load(8'h81);
        set_mode(2'b01); rotate = 1'b1; start = 1'b1; amount = 4'd8; tick();
        start = 1'b0; set_mode(2'b00); rotate = 1'b0;
        wait_done(15, n);
        check("rot8_cycles", 32'(n), 32'd7);
        check("rot8_out", 32'(out), 32'h81);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/universal_shift_register_n.md
Name: universal_shift_register_n

Overview:
- Parametrised N-bit universal shift register; successor to the 1-bit universal cell.
- Modes: hold, shift right, shift left, parallel load.
- Adds a multi-step shift engine: one start request performs AMOUNT shifts over successive cycles, with a busy/done handshake.
- Sits in datapath exercises as the shared register for serial/parallel conversion and for shift-by-k operations.

Parameters:
- WIDTH, 8, register width in bits (>=2).
- CNT_W, 4, width of the shift-amount input; amounts range 0..2^CNT_W-1. Amounts above WIDTH are legal and shift all bits out.

Ports:
- clk  input  1  rising-edge clock
- clear  input  1  asynchronous active-low reset
- S1  input  1  mode bit 1
- S0  input  1  mode bit 0
- right_in  input  1  serial input entering at MSB on a right shift
- left_in  input  1  serial input entering at LSB on a left shift
- inputs  input  WIDTH  parallel load data
- start  input  1  request a multi-step shift
- amount  input  CNT_W  number of shifts for a start request
- out  output  WIDTH  register contents
- right_shift  output  1  out[0], the bit leaving on a right shift
- left_shift  output  1  out[WIDTH-1], the bit leaving on a left shift
- busy  output  1  multi-step shift in progress
- done  output  1  one-cycle completion pulse

Behaviour:
- Reset: clear=0 asynchronously forces out=0, state IDLE, count=0, busy=0, done=0. This applies mid-operation too; any pending shift is abandoned with no done pulse.
- Mode encoding {S1,S0}:
  - 00: hold.
  - 01: shift right, out <= {right_in, out[W-1:1]}.
  - 10: shift left, out <= {out[W-2:0], left_in}.
  - 11: parallel load, out <= inputs.
- IDLE with start=0: the mode operation is applied at every rising edge (single-step behaviour). done=0.
- IDLE with start=1 and mode 01/10:
  - Direction is latched.
  - If amount=0: no change to out, done=1 in the following cycle, stay IDLE.
  - If amount>=1: the first shift is performed at the same edge and count is loaded with amount-1.
    - count>0: go to SHIFT with busy=1.
    - count=0 (amount=1): stay IDLE with done=1 next cycle.
- IDLE with start=1 and mode 00/11: start is ignored and the single-step mode applies. No done pulse.
- SHIFT state:
  - Each edge performs one shift in the latched direction and decrements count.
  - Serial inputs are sampled live at each shift edge.
  - On the edge where count goes 1->0: go to IDLE, busy=0, done=1 for exactly one cycle.
  - S1, S0, start, amount and inputs are all ignored while busy=1.
- Timing: for amount=N>=1 sampled at edge k, shifts occur at edges k..k+N-1. busy is high for N-1 cycles. done is high in the cycle after edge k+N-1.
- Back-to-back: start may be asserted in the cycle where done=1 (state is IDLE) and is accepted.
- done and busy are registered outputs, never both high.

Optional Feature:
- Macro USR_ROTATE_EN.
- When defined, an extra input port rotate (1 bit) is present, sampled with start and latched for the operation (sampled live during single-step operation).
- With rotate=1, the bit shifted out re-enters at the opposite end instead of right_in/left_in:
  - right rotate: out <= {out[0], out[W-1:1]}.
  - left rotate: out <= {out[W-2:0], out[W-1]}.
- When undefined, the port does not exist and shifts always use the serial inputs.

Decomposition:
- Package usr_pkg holds:
  - mode constants MODE_HOLD=2'b00, MODE_SHR=2'b01, MODE_SHL=2'b10, MODE_LOAD=2'b11;
  - state typedef {IDLE, SHIFT}.
- One combinational sub-module, usr_step. It computes the one-step next value from out, the mode, the serial inputs and (optionally) rotate. It is shared by the single-step path and the SHIFT state.

Test Plan (WIDTH=8, CNT_W=4):
- clear=0 while out=8'hA5 and busy=1 -> out=0, busy=0, done=0 immediately without a clock edge; no done pulse after release.
- mode 11, inputs=8'h3C, one edge; then mode 01, right_in=1, one edge -> out=8'h3C, then 8'h9E.
- out=8'h81, mode 10, start=1, amount=3, left_in=0 -> busy high 2 cycles, out=8'h08 with done=1 for one cycle, then done=0.
- start=1, amount=0, mode 01, out=8'h55 -> out stays 8'h55, done=1 next cycle, busy never high.
- During busy, drive mode 11, inputs=8'hFF and start=1 -> ignored; the result equals the uninterrupted shift. Asserting start during the done cycle starts a new operation.
- USR_ROTATE_EN: out=8'h81, mode 01, rotate=1, start, amount=4 -> out=8'h18, done pulse; amount=8 returns the original value.
